// File: rtl/mux_rr_pkg.sv
// Shared constants and helpers for the registered
// N-channel select block.
package mux_rr_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  localparam int   MAX_CH     = 16;

  function automatic logic [MAX_CH-1:0] idx2oh(
    input logic [3:0] idx
  );
    logic [MAX_CH-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_rr_reg_arb.sv
// Grant logic for fixed/round-robin select plus
// the round-robin pointer.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] req,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    hi_idx;
  logic [SEL_W-1:0]    lo_idx;
  logic [SEL_W-1:0]    rr_idx;
  logic                hi_found;
  logic                lo_found;
  logic [3:0]          sel4;
  logic [3:0]          rr4;
  logic [CHANNELS-1:0] fix_grant;
  logic [CHANNELS-1:0] rr_grant;

  assign sel4 = 4'(sel);
  assign rr4  = 4'(rr_idx);

  // An out-of-range sel lands above CHANNELS and is truncated away.
  assign fix_grant = CHANNELS'(idx2oh(sel4)) & req;

  // Two passes: first hit at/after rr_ptr, else lowest hit overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (req[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_idx   = SEL_W'(i);
      end
      if (req[i] && !hi_found && (SEL_W'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = SEL_W'(i);
      end
    end
    rr_idx = hi_found ? hi_idx : lo_idx;
  end

  assign rr_grant = lo_found ? CHANNELS'(idx2oh(rr4)) : '0;

  always_comb begin
    grant     = fix_grant;
    grant_idx = sel;
    if (mode == MODE_RR) begin
      grant     = rr_grant;
      grant_idx = rr_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance && (mode == MODE_RR)) begin
      if (grant_idx == SEL_W'(CHANNELS-1))
        rr_ptr <= '0;
      else
        rr_ptr <= grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mux_rr_reg.sv
// Registered N-channel select with per-channel
// valid/ready and fixed or round-robin arbitration.
module mux_rr_reg
  import mux_rr_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    sel_data;
  logic                load_en;
  logic                xfer;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (in_valid),
    .mode      (mode),
    .sel       (sel),
    .advance   (xfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign load_en = ~out_valid | out_ready;

  // Ready is forced low during reset so nothing is accepted.
  assign in_ready = rst_n ? (grant & {CHANNELS{load_en}}) : '0;
  assign xfer     = |in_ready;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i])
        sel_data = sel_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_reg.sv
// Scoreboard bench for mux_rr_reg with an 8-channel
// and a 5-channel instance.
module tb_mux_rr_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         m8, ov8, or8;
  logic [2:0]   s8, oc8;
  logic [255:0] d8;
  logic [7:0]   v8, ir8;
  logic [31:0]  od8;

  logic         m5, ov5, or5;
  logic [2:0]   s5, oc5;
  logic [159:0] d5;
  logic [4:0]   v5, ir5;
  logic [31:0]  od5;

  mux_rr_reg #(.WIDTH(32), .CHANNELS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .mode(m8), .sel(s8),
    .in_data(d8), .in_valid(v8), .in_ready(ir8),
    .out_data(od8), .out_ch(oc8), .out_valid(ov8),
    .out_ready(or8)
  );

  mux_rr_reg #(.WIDTH(32), .CHANNELS(5)) u5 (
    .clk(clk), .rst_n(rst_n), .mode(m5), .sel(s5),
    .in_data(d5), .in_valid(v5), .in_ready(ir5),
    .out_data(od5), .out_ch(oc5), .out_valid(ov5),
    .out_ready(or5)
  );

  typedef struct {
    int          ch;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          nerr = 0;
  int          nchk = 0;
  int          mp[2];
  bit          mv[2];
  logic [31:0] mdat[2];
  int          mch[2];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mgrant(
    input int n, input logic m, input int s,
    input logic [15:0] v, input int p);
    logic [15:0] r;
    int          idx;
    r = '0;
    if (m == 1'b0) begin
      if (s < n && v[s]) r[s] = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        idx = (p + k) % n;
        if (v[idx] && r == 16'h0) r[idx] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic rnd8();
    for (int i = 0; i < 8; i++) d8[i*32 +: 32] = $urandom;
  endtask

  task automatic rnd5();
    for (int i = 0; i < 5; i++) d5[i*32 +: 32] = $urandom;
  endtask

  task automatic step(input int f);
    int          n, s, gi;
    logic [15:0] v, g, ir;
    logic        m;
    bit          ordy, le;
    exp_t        e;
    #1;
    n = (f != 0) ? 5 : 8;
    if (f != 0) begin
      v = 16'(v5); m = m5; s = int'(s5);
      ordy = or5; ir = 16'(ir5);
    end else begin
      v = 16'(v8); m = m8; s = int'(s8);
      ordy = or8; ir = 16'(ir8);
    end
    le = !mv[f] || ordy;
    g  = le ? mgrant(n, m, s, v, mp[f]) : 16'h0;
    chk("in_ready", 64'(ir), 64'(g));
    gi = -1;
    for (int i = 0; i < n; i++) if (g[i]) gi = i;
    if (gi >= 0) begin
      e.ch   = gi;
      e.data = (f != 0) ? d5[gi*32 +: 32] : d8[gi*32 +: 32];
      sb.push_back(e);
      if (m) mp[f] = (gi + 1) % n;
      mv[f] = 1'b1;
    end else if (ordy) begin
      mv[f] = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", 64'((f != 0) ? ov5 : ov8), 64'(mv[f]));
    if (gi >= 0 && sb.size() > 0) begin
      e = sb.pop_front();
      mdat[f] = e.data;
      mch[f]  = e.ch;
    end
    chk("out_data", 64'((f != 0) ? od5 : od8), 64'(mdat[f]));
    chk("out_ch", 64'((f != 0) ? oc5 : oc8), 64'(mch[f]));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mp[i] = 0; mv[i] = 1'b0; mdat[i] = '0; mch[i] = 0;
    end
    m8 = 1'b0; s8 = '0; d8 = '0; v8 = 8'hFF; or8 = 1'b1;
    m5 = 1'b0; s5 = '0; d5 = '0; v5 = '0; or5 = 1'b1;

    #12;
    chk("rst_in_ready", 64'(ir8), 64'h0);
    chk("rst_out_valid", 64'(ov8), 64'h0);
    chk("rst_out_data", 64'(od8), 64'h0);
    v8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) step(0);

    rnd8(); s8 = 3'd3; v8 = 8'hFF;
    d8[3*32 +: 32] = 32'hDEAD_BEEF;
    step(0);
    chk("fix_ch3", 64'(od8), 64'hDEAD_BEEF);
    rnd8(); s8 = 3'd7;
    step(0);
    chk("fix_ch7", 64'(oc8), 64'd7);
    v8 = '0;
    step(0);

    m8 = 1'b1; v8 = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      rnd8();
      step(0);
      chk("rr_seq", 64'(oc8), 64'(k % 8));
    end
    v8 = 8'b0010_0100;
    for (int k = 0; k < 4; k++) begin
      rnd8();
      step(0);
      chk("rr_alt", 64'(oc8), 64'((k % 2 != 0) ? 5 : 2));
    end

    m8 = 1'b0; s8 = 3'd4; v8 = 8'hFF; rnd8();
    d8[4*32 +: 32] = 32'h1234_5678;
    step(0);
    or8 = 1'b0; m8 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rnd8();
      step(0);
      chk("stall_hold", 64'(od8), 64'h1234_5678);
    end
    or8 = 1'b1;
    for (int k = 0; k < 2; k++) begin
      rnd8();
      step(0);
      chk("resume_ch", 64'(oc8), 64'(6 + k));
    end

    m8 = 1'b0; s8 = 3'd1; rnd8();
    step(0);
    or8 = 1'b0;
    step(0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ov8), 64'h0);
    chk("arst_data", 64'(od8), 64'h0);
    chk("arst_ch", 64'(oc8), 64'h0);
    chk("arst_ready", 64'(ir8), 64'h0);
    mv[0] = 1'b0; mp[0] = 0; mdat[0] = '0; mch[0] = 0;
    sb.delete();
    @(posedge clk);
    #1;
    chk("rst_no_xfer", 64'(ov8), 64'h0);
    rst_n = 1'b1;
    m8 = 1'b1; v8 = 8'b0101_0000; or8 = 1'b1; rnd8();
    step(0);
    chk("post_rst_rr", 64'(oc8), 64'd4);

    m5 = 1'b1; v5 = 5'h1F;
    for (int k = 0; k < 6; k++) begin
      rnd5();
      step(1);
      chk("rr5_seq", 64'(oc5), 64'(k % 5));
    end
    m5 = 1'b0; s5 = 3'd6;
    step(1);
    step(1);
    chk("sel6_idle", 64'(ov5), 64'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
